// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Detector states and the pattern-length legality check live here.
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // A pattern must hold at least two bits and fit the history register.
    function automatic logic len_ok(input logic [31:0] len, input logic [31:0] max_len);
        return (len >= 32'd2) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating match counter for seq_detector_prog.
// Only instantiated when SEQDET_COUNT_EN is defined.
module seq_det_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count increments, holding at all-ones; clear has priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-sequence detector with run-time pattern/length load.
// Build option: SEQDET_COUNT_EN builds the saturating match counter (else match_count = 0).
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    seq_state_t          r_state;
    logic [MAX_LEN-1:0]  r_hist;
    logic [MAX_LEN-1:0]  r_pat;
    logic [LEN_W-1:0]    r_fill;
    logic [LEN_W-1:0]    r_len;
    logic                r_ovl;
    logic                r_z;
    logic                r_cfg_err;

    logic                w_cfg_legal;
    logic                w_accept;
    logic [MAX_LEN-1:0]  w_hist_nxt;
    logic [MAX_LEN-1:0]  w_mask;
    logic [LEN_W:0]      w_fill_p1;
    logic                w_window_full;
    logic                w_match;

    // Next-history, window-complete and match qualification for the incoming bit.
    always_comb begin
        w_cfg_legal   = len_ok(32'(cfg_len), 32'(MAX_LEN));
        w_accept      = x_valid && !cfg_load && (r_state != UNCFG);
        w_hist_nxt    = {r_hist[MAX_LEN-2:0], x};
        w_fill_p1     = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
        w_window_full = (w_fill_p1 >= {1'b0, r_len});
        w_mask        = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (32'(i) < 32'(r_len));
        end
        // Stale history beyond fill is harmless: a match also needs a full window.
        w_match = w_accept && w_window_full &&
                  ((w_hist_nxt & w_mask) == (r_pat & w_mask));
    end

    // Detector FSM with registered match pulse and sticky config error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= UNCFG;
            r_hist    <= {MAX_LEN{1'b0}};
            r_pat     <= {MAX_LEN{1'b0}};
            r_fill    <= {LEN_W{1'b0}};
            r_len     <= {LEN_W{1'b0}};
            r_ovl     <= 1'b0;
            r_z       <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (cfg_load) begin
            r_z <= 1'b0;
            if (w_cfg_legal) begin
                r_state   <= FILL;
                r_pat     <= cfg_pattern;
                r_len     <= cfg_len;
                r_ovl     <= cfg_overlap;
                r_hist    <= {MAX_LEN{1'b0}};
                r_fill    <= {LEN_W{1'b0}};
                r_cfg_err <= 1'b0;
            end else begin
                r_state   <= UNCFG;
                r_cfg_err <= 1'b1;
            end
        end else begin
            case (r_state)
                UNCFG: begin
                    r_z <= 1'b0;
                end
                FILL, RUN: begin
                    if (x_valid) begin
                        r_hist <= w_hist_nxt;
                        if (w_match) begin
                            r_z <= 1'b1;
                            if (r_ovl) begin
                                r_state <= RUN;
                                r_fill  <= r_len;
                            end else begin
                                r_state <= FILL;
                                r_fill  <= {LEN_W{1'b0}};
                            end
                        end else begin
                            r_z <= 1'b0;
                            if (w_window_full) begin
                                r_state <= RUN;
                                r_fill  <= r_len;
                            end else begin
                                r_state <= FILL;
                                r_fill  <= w_fill_p1[LEN_W-1:0];
                            end
                        end
                    end else begin
                        r_z <= 1'b0;
                    end
                end
                default: begin
                    r_state <= UNCFG;
                    r_z     <= 1'b0;
                end
            endcase
        end
    end

    assign z       = r_z;
    assign cfg_err = r_cfg_err;

`ifdef SEQDET_COUNT_EN
    seq_det_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk   (clk),
        .clr   (reset),
        .inc   (w_match),
        .count (match_count)
    );
`else
    assign match_count = {CNT_W{1'b0}};
`endif

endmodule
